main_memory_ctrl: RTL

- Line-granular main-memory controller directly downstream of the L2 cache.
- Serves the L2's memory-side requests: line fetch on L2 miss, dirty-line writeback on eviction.
- Holds a 128-bit-per-line backing store, models fixed access latencies, and signals completion with a one-cycle mem_ready pulse.
- Tolerates the L2's registered request outputs, which stay high one cycle after mem_ready.

---
 rtl/main_memory_ctrl_if.sv | 21 ++
 rtl/main_memory_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl_if.sv
// L2 <-> main-memory line bus. The L2 drives the master side and the
// controller takes the slave side.
interface main_memory_ctrl_if;
   logic         mem_read_req;
   logic         mem_write_req;
   logic [31:0]  mem_addr;
   logic [127:0] mem_write_data;
   logic [127:0] mem_read_data;
   logic         mem_ready;
   logic         mem_busy;

   modport master (
      output mem_read_req, mem_write_req, mem_addr, mem_write_data,
      input  mem_read_data, mem_ready, mem_busy
   );

   modport slave (
      input  mem_read_req, mem_write_req, mem_addr, mem_write_data,
      output mem_read_data, mem_ready, mem_busy
   );
endinterface

// File: rtl/main_memory_ctrl.sv
// Line-granular main-memory controller sitting below the L2.
// Serves one line read or line write at a time with a fixed latency and
// signals completion with a one-cycle mem_ready pulse. A RELEASE state
// absorbs the L2's registered request lines, which stay high for a cycle
// after mem_ready, so a request is never accepted twice.
// Optional build macro MAIN_MEMORY_CTRL_STATS_EN adds saturating
// rd_count / wr_count completion counters.
// READ_LATENCY and WRITE_LATENCY must both be at least 1.
module main_memory_ctrl #(
   parameter int LINE_IDX_W    = 10,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst,
   main_memory_ctrl_if.slave   bus
`ifdef MAIN_MEMORY_CTRL_STATS_EN
   ,
   output logic [31:0]         rd_count,
   output logic [31:0]         wr_count
`endif
);

   localparam int DEPTH   = 1 << LINE_IDX_W;
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_WAIT,
      S_WRITE_WAIT,
      S_RELEASE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [LINE_IDX_W-1:0] r_idx;
   logic [127:0]          r_wdata;
   logic [127:0]          r_rdata;
   logic                  r_ready;

   // Backing store is deliberately not reset; it powers up as all-zero lines.
   logic [127:0]          r_mem [DEPTH] = '{default: '0};

   logic [LINE_IDX_W-1:0] w_idx;
   logic                  w_acc_wr;
   logic                  w_acc_rd;
   logic                  w_rd_done;
   logic                  w_wr_done;
   logic                  w_waiting;
   logic                  w_unused_addr;

   // Byte offset and the bits above the index are don't-care, so lines alias.
   assign w_idx         = bus.mem_addr[LINE_IDX_W+3:4];
   assign w_unused_addr = ^{bus.mem_addr[31:LINE_IDX_W+4], bus.mem_addr[3:0]};
   assign w_waiting     = (r_state == S_READ_WAIT) || (r_state == S_WRITE_WAIT);

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state and per-cycle strobes; a write beats a simultaneous read.
   always_comb begin
      w_next    = r_state;
      w_acc_wr  = 1'b0;
      w_acc_rd  = 1'b0;
      w_rd_done = 1'b0;
      w_wr_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.mem_write_req) begin
               w_acc_wr = 1'b1;
               w_next   = S_WRITE_WAIT;
            end else if (bus.mem_read_req) begin
               w_acc_rd = 1'b1;
               w_next   = S_READ_WAIT;
            end
         end
         S_READ_WAIT: begin
            if (r_cnt == '0) begin
               w_rd_done = 1'b1;
               w_next    = S_RELEASE;
            end
         end
         S_WRITE_WAIT: begin
            if (r_cnt == '0) begin
               w_wr_done = 1'b1;
               w_next    = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!bus.mem_read_req && !bus.mem_write_req) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Capture request at acceptance, count latency, return read data and ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= w_rd_done | w_wr_done;
         if (w_acc_wr) begin
            r_cnt   <= CNT_W'(WRITE_LATENCY - 1);
            r_idx   <= w_idx;
            r_wdata <= bus.mem_write_data;
         end else if (w_acc_rd) begin
            r_cnt   <= CNT_W'(READ_LATENCY - 1);
            r_idx   <= w_idx;
         end else if (w_waiting && (r_cnt != '0)) begin
            r_cnt   <= r_cnt - 1'b1;
         end
         if (w_rd_done) r_rdata <= r_mem[r_idx];
      end
   end

   // Store commit happens only on the completing edge, so an aborted write
   // never reaches the array.
   always_ff @(posedge clk) begin
      if (w_wr_done) r_mem[r_idx] <= r_wdata;
   end

   assign bus.mem_read_data = r_rdata;
   assign bus.mem_ready     = r_ready;
   assign bus.mem_busy      = (r_state != S_IDLE);

`ifdef MAIN_MEMORY_CTRL_STATS_EN
   logic [31:0] r_rd_count;
   logic [31:0] r_wr_count;

   // Saturating completion counters, bumped alongside the mem_ready pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_rd_done && (r_rd_count != 32'hFFFF_FFFF)) r_rd_count <= r_rd_count + 32'd1;
         if (w_wr_done && (r_wr_count != 32'hFFFF_FFFF)) r_wr_count <= r_wr_count + 32'd1;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

endmodule
